data_mem_ctrl: RTL and testbench

Single-port word-organised data memory slave that terminates the load/store unit's req/gnt/rvalid data interface.
- Grants requests after a programmable number of wait states.
- Performs byte-enabled writes.
- Returns read data through a fixed-latency response pipeline.
- Flags out-of-range accesses.
It is the core data RAM for simulation and FPGA builds, sitting directly downstream of the load/store unit.

---
 rtl/data_mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port, word-organised data RAM slave for the load/store
// unit's req/gnt/rvalid interface. It grants after a programmable number of wait
// states, performs byte-enabled writes, and returns reads through a fixed-latency
// response pipeline. Accesses outside [BASE_ADDR, BASE_ADDR + DEPTH*4) are
// flagged rather than performed.
module data_mem_ctrl #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        stall_i,
  input  logic        err_clr_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        err_sticky_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  // One past the last mapped byte; 33 bits so a window ending at 4 GiB cannot wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);

  // One slot of the read response pipeline.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [3:0]    wcnt_q;
  logic          gnt;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic          err_set;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem [DEPTH];
  resp_t         rsp_new;
  resp_t         pipe_q [RD_LATENCY];
  logic          err_sticky_q;

  // Address decode. BASE_ADDR is aligned to the window size, so the word index
  // is simply the low address bits above the byte offset.
  always_comb begin
    in_range = (data_addr_i >= BASE_ADDR) && ({1'b0, data_addr_i} < END_ADDR);
    word_idx = data_addr_i[AW+1:2];
  end

  // Grant once the request has waited WAIT_CYCLES unstalled cycles; held low in reset
  // so a request present during reset can neither write memory nor raise an error.
  always_comb begin
    gnt     = rst_ni & data_req_i & ~stall_i & (wcnt_q == WAIT_LIM);
    wr_en   = gnt & data_we_i & in_range;
    rd_en   = gnt & ~data_we_i;
    err_set = gnt & ~in_range;
  end

  assign data_gnt_o = gnt;

  // Wait-state counter: counts unstalled waiting cycles, restarts on grant or withdrawal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: all clocked state uses non-blocking assignment so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else if (!data_req_i || gnt) begin
      wcnt_q <= '0;
    end else if (!stall_i) begin
      wcnt_q <= wcnt_q + 4'd1;
    end
  end

  // Byte-enabled write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset on purpose; resetting it would prevent RAM
    // inference and contents are expected to survive a core reset.
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Build the response entry for a read granted this cycle; out-of-range reads
  // carry zero data, and non-read cycles carry an all-zero (invalid) entry.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path leaves it
    // unassigned, which would infer a latch.
    rsp_new       = '0;
    rsp_new.valid = rd_en;
    rsp_new.err   = rd_en & ~in_range;
    if (rd_en && in_range) begin
      rsp_new.data = mem[word_idx];
    end
  end

  // Fixed-latency response shift pipeline; reset discards everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= rsp_new;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Invalid slots always hold zero data, so rdata is zero whenever rvalid is low.
  assign data_rvalid_o = pipe_q[RD_LATENCY-1].valid;
  assign data_err_o    = pipe_q[RD_LATENCY-1].err;
  assign data_rdata_o  = pipe_q[RD_LATENCY-1].data;

  // Sticky out-of-range flag; a new error in the same cycle takes priority over a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_sticky_q <= 1'b0;
    end else if (err_set) begin
      err_sticky_q <= 1'b1;
    end else if (err_clr_i) begin
      err_sticky_q <= 1'b0;
    end
  end

  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: four data_mem_ctrl instances with different wait/latency
// settings share the address/data buses; each has its own req line so their
// memories evolve independently. Per-cycle vectors in a table, then a
// hand-written reset-while-in-flight sequence.
module tb_data_mem_ctrl;

  localparam logic [31:0] B = 32'h0001_0000;

  typedef enum logic [1:0] {OP_IDLE, OP_RD, OP_WR} op_e;

  typedef struct {
    int          dut;
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic        clr;
    logic        e_gnt;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_sticky;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        stall;
  logic        clr;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [3:0]  err;
  logic [3:0]  sticky;
  logic [31:0] rdata [4];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: wait 0 / lat 1, dut1: wait 3 / lat 1, dut2: wait 0 / lat 3, dut3: wait 0 / lat 2
  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_ctrl #(
      .DEPTH      (1024),
      .BASE_ADDR  (B),
      .WAIT_CYCLES((g == 1) ? 3 : 0),
      .RD_LATENCY ((g == 2) ? 3 : ((g == 3) ? 2 : 1))
    ) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .data_req_i   (req[g]),
      .data_addr_i  (addr),
      .data_we_i    (we),
      .data_be_i    (be),
      .data_wdata_i (wdata),
      .stall_i      (stall),
      .err_clr_i    (clr),
      .data_gnt_o   (gnt[g]),
      .data_rvalid_o(rvalid[g]),
      .data_rdata_o (rdata[g]),
      .data_err_o   (err[g]),
      .err_sticky_o (sticky[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int d, input op_e op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input logic st, input logic cl);
    req = '0;
    if (op != OP_IDLE) req[d] = 1'b1;
    we    = (op == OP_WR);
    addr  = a;
    wdata = wd;
    be    = b;
    stall = st;
    clr   = cl;
  endtask

  task automatic row(input int d, input op_e op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] b, input logic st, input logic cl,
                     input logic eg, input logic ev, input logic [31:0] ed,
                     input logic ee, input logic es);
    vec_t v;
    v.dut = d; v.op = op; v.addr = a; v.wdata = wd; v.be = b; v.stall = st; v.clr = cl;
    v.e_gnt = eg; v.e_rvalid = ev; v.e_rdata = ed; v.e_err = ee; v.e_sticky = es;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input int d, input logic eg, input logic ev,
                               input logic [31:0] ed, input logic ee, input logic es);
    check({tag, " gnt"},    32'(gnt[d]),    32'(eg));
    check({tag, " rvalid"}, 32'(rvalid[d]), 32'(ev));
    check({tag, " rdata"},  rdata[d],       ed);
    check({tag, " err"},    32'(err[d]),    32'(ee));
    check({tag, " sticky"}, 32'(sticky[d]), 32'(es));
  endtask

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    apply(0, OP_IDLE, '0, '0, '0, 1'b0, 1'b0);

    // ---- dut0 (wait 0, latency 1): write/read, byte enables, range errors ----
    row(0, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(0, OP_WR,   B+8, 32'hDEADBEEF, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_RD,   B+8, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'hDEADBEEF, 0, 0);
    row(0, OP_WR,   B+16, 32'h11223344, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_WR,   B+16, 32'hAABBCCDD, 4'b0110, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_RD,   B+16, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_WR,   B+20, 32'h55667788, 4'hF, 0, 0,  1, 1, 32'h11BBCC44, 0, 0);
    row(0, OP_RD,   B+20, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_RD,   B+8,  '0, 4'h0, 0, 0,  1, 1, 32'h55667788, 0, 0);
    row(0, OP_WR,   B,    32'h0BADF00D, 4'hF, 0, 0,  1, 1, 32'hDEADBEEF, 0, 0);
    row(0, OP_WR,   B+32'hFFC, 32'hCAFEF00D, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_RD,   B+32'hFFC, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(0, OP_RD,   32'h0000_0FFC, '0, 4'h0, 0, 0,  1, 1, 32'hCAFEF00D, 0, 0);
    row(0, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h0, 1, 1);
    row(0, OP_WR,   32'h0001_1000, 32'hFFFFFFFF, 4'hF, 0, 0,  1, 0, 32'h0, 0, 1);
    row(0, OP_RD,   B, '0, 4'h0, 0, 1,  1, 0, 32'h0, 0, 1);
    row(0, OP_RD,   32'h0000_FFFC, '0, 4'h0, 0, 1,  1, 1, 32'h0BADF00D, 0, 0);
    row(0, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h0, 1, 1);
    row(0, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 1);

    // ---- dut2 (latency 3): three back-to-back reads ----
    row(2, OP_WR,   B,   32'h00000A00, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(2, OP_WR,   B+4, 32'h00000B04, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(2, OP_WR,   B+8, 32'h00000C08, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(2, OP_RD,   B,   '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(2, OP_RD,   B+4, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(2, OP_RD,   B+8, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(2, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h00000A00, 0, 0);
    row(2, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h00000B04, 0, 0);
    row(2, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h00000C08, 0, 0);
    row(2, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);

    // ---- dut1 (wait 3): gnt on 4th req cycle, flush, stall ----
    row(1, OP_WR,   B, 32'h12345678, 4'hF, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_WR,   B, 32'h12345678, 4'hF, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_WR,   B, 32'h12345678, 4'hF, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_WR,   B, 32'h12345678, 4'hF, 0, 0,  1, 0, 32'h0, 0, 0);
    row(1, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_WR,   B, 32'hFFFFFFFF, 4'hF, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_WR,   B, 32'hFFFFFFFF, 4'hF, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(1, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h12345678, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 1, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 1, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  0, 0, 32'h0, 0, 0);
    row(1, OP_RD,   B, '0, 4'h0, 0, 0,  1, 0, 32'h0, 0, 0);
    row(1, OP_IDLE, '0, '0, 4'h0, 0, 0,  0, 1, 32'h12345678, 0, 0);

    // Reset state of every instance.
    repeat (2) @(negedge clk);
    #2;
    for (int d = 0; d < 4; d++) begin
      check_outputs($sformatf("reset dut%0d", d), d, 0, 0, 32'h0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven part: one row per clock cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i].dut, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].be,
            vecs[i].stall, vecs[i].clr);
      #2;
      check_outputs($sformatf("row%0d dut%0d", i, vecs[i].dut), vecs[i].dut,
                    vecs[i].e_gnt, vecs[i].e_rvalid, vecs[i].e_rdata,
                    vecs[i].e_err, vecs[i].e_sticky);
    end

    // ---- dut3 (latency 2): reset with two reads in flight ----
    @(negedge clk);
    apply(3, OP_WR, B+32'h20, 32'h600DDA7A, 4'hF, 1'b0, 1'b0);
    #2 check("rst_seq write gnt", 32'(gnt[3]), 32'h1);
    @(negedge clk);
    apply(3, OP_RD, B+32'h20, '0, 4'h0, 1'b0, 1'b0);
    #2 check("rst_seq read1 gnt", 32'(gnt[3]), 32'h1);
    @(negedge clk);
    apply(3, OP_RD, 32'h0002_0000, '0, 4'h0, 1'b0, 1'b0);
    #2 check("rst_seq read2 gnt", 32'(gnt[3]), 32'h1);
    check("rst_seq read2 rvalid", 32'(rvalid[3]), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_outputs("rst_seq in reset", 3, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    apply(3, OP_IDLE, '0, '0, 4'h0, 1'b0, 1'b0);
    #2 check("rst_seq held rvalid", 32'(rvalid[3]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #2 check($sformatf("rst_seq post c%0d rvalid", c), 32'(rvalid[3]), 32'h0);
      check($sformatf("rst_seq post c%0d sticky", c), 32'(sticky[3]), 32'h0);
    end
    @(negedge clk);
    apply(3, OP_RD, B+32'h20, '0, 4'h0, 1'b0, 1'b0);
    #2 check("rst_seq reread gnt", 32'(gnt[3]), 32'h1);
    @(negedge clk);
    apply(3, OP_IDLE, '0, '0, 4'h0, 1'b0, 1'b0);
    #2 check("rst_seq reread rvalid early", 32'(rvalid[3]), 32'h0);
    @(negedge clk);
    #2 check_outputs("rst_seq reread resp", 3, 0, 1, 32'h600DDA7A, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
